// File: rtl/rvcpu_pkg.sv
// Shared decode types: immediate kinds, opcode constants and the decode payload.
package rvcpu;

    localparam int XLEN = 32;

    // imm_none is zero so a cleared payload register reads as "no immediate".
    typedef enum logic [3:0] {
        imm_none     = 4'd0,
        alu_imm      = 4'd1,
        load_offset  = 4'd2,
        store_offset = 4'd3,
        br_offset    = 4'd4,
        jal_offset   = 4'd5,
        jalr_offset  = 4'd6,
        ui_imm       = 4'd7,
        uimm         = 4'd8
    } imm_type_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_t       immtype;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } decode_payload_t;

    typedef struct packed {
        imm_type_t immtype;
        logic      illegal;
    } opc_class_t;

endpackage

// File: rtl/gen_imm.sv
// Immediate generator: assembles the sign/zero-extended immediate for a given kind.
// Only instr[31:7] carries immediate bits, so the opcode field is not an input.
module gen_imm
    import rvcpu::*;
(
    input  logic [31:7] i_instr,
    input  imm_type_t   i_immtype,
    output logic [31:0] o_imm
);

    // Select the bit-scatter for each immediate format; unknown kinds give 0.
    always_comb begin
        o_imm = '0;
        case (i_immtype)
            alu_imm, load_offset, jalr_offset:
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            store_offset:
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            br_offset:
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            jal_offset:
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            ui_imm:
                o_imm = {i_instr[31:12], 12'h000};
            uimm:
                o_imm = {27'h0, i_instr[19:15]};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: classifies the incoming word, builds its immediate and holds
// the result in a main/skid register pair so in_ready is a plain flop.
module decode_stage
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_instr,
    input  logic [Width-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_imm,
    output imm_type_t        out_immtype,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [Width-1:0] out_pc,
    output logic             out_illegal
);

    // Encoded as {M.valid, S.valid}; 2'b01 never occurs.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } skid_state_t;

    skid_state_t     r_state, w_state_nxt;
    logic            r_in_ready;
    decode_payload_t r_m, r_s;
    decode_payload_t w_new;
    opc_class_t      w_cls;
    logic [31:0]     w_imm;
    logic            w_acc, w_ret;
    logic            w_load_m, w_load_s, w_m_from_s;

    function automatic opc_class_t classify(input logic [31:0] instr);
        opc_class_t c;
        c.immtype = imm_none;
        c.illegal = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM: c.immtype = alu_imm;
            OPC_LOAD:   c.immtype = load_offset;
            OPC_STORE:  c.immtype = store_offset;
            OPC_BRANCH: c.immtype = br_offset;
            OPC_JAL:    c.immtype = jal_offset;
            OPC_JALR:   c.immtype = jalr_offset;
            OPC_LUI,
            OPC_AUIPC:  c.immtype = ui_imm;
            OPC_SYSTEM: c.immtype = instr[14] ? uimm : imm_none;
            OPC_OP:     c.immtype = imm_none;
            default:    c.illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) c.illegal = 1'b1;
        return c;
    endfunction

    assign w_cls = classify(in_instr);

    gen_imm u_gen_imm (
        .i_instr   (in_instr[31:7]),
        .i_immtype (w_cls.immtype),
        .o_imm     (w_imm)
    );

    // Pack the decode of the incoming word so it can be captured in one load.
    always_comb begin
        w_new         = '0;
        w_new.imm     = w_imm;
        w_new.immtype = w_cls.immtype;
        w_new.rs1     = in_instr[19:15];
        w_new.rs2     = in_instr[24:20];
        w_new.rd      = in_instr[11:7];
        w_new.pc      = in_pc;
        w_new.illegal = w_cls.illegal;
    end

    assign w_acc = in_valid & r_in_ready;
    assign w_ret = r_state[1] & out_ready;

    // Next occupancy and which payload register loads; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_load_m    = 1'b0;
        w_load_s    = 1'b0;
        w_m_from_s  = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = ST_ONE;
                        w_load_m    = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_ret) begin
                        w_load_m = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = ST_FULL;
                        w_load_s    = 1'b1;
                    end else if (w_ret) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_ret) begin
                        w_state_nxt = ST_ONE;
                        w_m_from_s  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Occupancy register; in_ready is precomputed from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Payload registers change only on a load, so stalled outputs hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            if (w_load_m)        r_m <= w_new;
            else if (w_m_from_s) r_m <= r_s;
            if (w_load_s)        r_s <= w_new;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_state[1];
    assign out_imm     = r_m.imm;
    assign out_immtype = r_m.immtype;
    assign out_rs1     = r_m.rs1;
    assign out_rs2     = r_m.rs2;
    assign out_rd      = r_m.rd;
    assign out_pc      = r_m.pc;
    assign out_illegal = r_m.illegal;

endmodule
